// File: rtl/mesh_term_tx.sv
// Terminal-side transmitter for one external mesh port: assembles user packets,
// queues them in a FIFO and presents the head to the router with a pending/pop handshake.
module mesh_term_tx #(
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 8,
    parameter int id_row     = 0,
    parameter int id_column  = 0,
    parameter int GAP        = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               usr_push,
    input  logic [3:0]         usr_row,
    input  logic [3:0]         usr_col,
    input  logic               usr_mode,
    input  logic [pckg_sz-18:0] usr_payload,
    output logic               usr_full,
    output logic               pndng_i_in,
    output logic [pckg_sz-1:0] data_out_i_in,
    input  logic               popin,
    output logic [15:0]        tx_count,
    output logic [15:0]        drop_count
);

    localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = $clog2(fifo_depth + 1);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_GAPW  = 2'd2;

    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_full;
    logic [1:0]         r_state;
    logic [3:0]         r_gap_cnt;
    logic [15:0]        r_tx_cnt, r_drop_cnt;

    logic               w_row_edge, w_col_edge, w_is_self, w_dst_ok;
    logic               w_wr, w_rd, w_drop;
    logic [CW-1:0]      w_count_nxt;
    logic [pckg_sz-1:0] w_pkt;

    assign w_row_edge = (usr_row == 4'd0 || usr_row == 4'(ROWS + 1)) &&
                        usr_col >= 4'd1 && usr_col <= 4'(COLUMS);
    assign w_col_edge = (usr_col == 4'd0 || usr_col == 4'(COLUMS + 1)) &&
                        usr_row >= 4'd1 && usr_row <= 4'(ROWS);
    // The own address gets no special treatment: it is sent iff it is a legal edge address.
    assign w_is_self  = (usr_row == 4'(id_row)) && (usr_col == 4'(id_column));
    assign w_dst_ok   = w_row_edge || w_col_edge || (w_is_self && (w_row_edge || w_col_edge));

    assign w_pkt  = {8'h00, usr_row, usr_col, usr_mode, usr_payload};

    // Full is judged on the registered flag, so a same-cycle pop cannot rescue a push.
    assign w_wr   = usr_push && w_dst_ok && !r_full;
    assign w_drop = usr_push && !w_wr;
    assign w_rd   = (r_state == S_PEND) && popin;

    assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < fifo_depth; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_pkt;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(fifo_depth));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_EMPTY;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                S_EMPTY: if (r_count != '0) r_state <= S_PEND;
                S_PEND: begin
                    if (popin) begin
                        if (GAP > 0) begin
                            r_state   <= S_GAPW;
                            r_gap_cnt <= 4'(GAP);
                        end else if (w_count_nxt == '0) begin
                            r_state <= S_EMPTY;
                        end
                    end
                end
                S_GAPW: begin
                    if (r_gap_cnt <= 4'd1) r_state <= (r_count != '0) ? S_PEND : S_EMPTY;
                    else                   r_gap_cnt <= r_gap_cnt - 4'd1;
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_rd && r_tx_cnt != 16'hFFFF)     r_tx_cnt   <= r_tx_cnt + 16'd1;
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign usr_full      = r_full;
    assign pndng_i_in    = (r_state == S_PEND);
    assign data_out_i_in = pndng_i_in ? r_mem[r_rd_ptr] : '0;
    assign tx_count      = r_tx_cnt;
    assign drop_count    = r_drop_cnt;

endmodule

// File: tb/tb_mesh_term_tx.sv
// Bench for mesh_term_tx: vector table, hand sequences, and randomized traffic
// against a queue-based model of the port behaviour.
module tb_mesh_term_tx;

    localparam int PW = 23;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          d_push, d_mode, d_pop, d_full, d_pnd;
    logic [3:0]    d_row, d_col;
    logic [PW-1:0] d_pl;
    logic [39:0]   d_data;
    logic [15:0]   d_tx, d_drop;

    logic          g_push, g_mode, g_pop, g_full, g_pnd;
    logic [3:0]    g_row, g_col;
    logic [PW-1:0] g_pl;
    logic [39:0]   g_data;
    logic [15:0]   g_tx, g_drop;

    mesh_term_tx #(.GAP(0)) u_dut (
        .clk(clk), .reset(reset), .usr_push(d_push), .usr_row(d_row), .usr_col(d_col),
        .usr_mode(d_mode), .usr_payload(d_pl), .usr_full(d_full), .pndng_i_in(d_pnd),
        .data_out_i_in(d_data), .popin(d_pop), .tx_count(d_tx), .drop_count(d_drop));

    mesh_term_tx #(.GAP(3)) u_gap (
        .clk(clk), .reset(reset), .usr_push(g_push), .usr_row(g_row), .usr_col(g_col),
        .usr_mode(g_mode), .usr_payload(g_pl), .usr_full(g_full), .pndng_i_in(g_pnd),
        .data_out_i_in(g_data), .popin(g_pop), .tx_count(g_tx), .drop_count(g_drop));

    int checks = 0;
    int errors = 0;

    logic [39:0] q[$];
    bit          m_pend = 1'b0;
    int          m_tx = 0;
    int          m_drop = 0;

    typedef struct {
        logic [3:0]    row;
        logic [3:0]    col;
        logic          mode;
        logic [PW-1:0] pl;
        bit            exp_ok;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [3:0] r, input logic [3:0] c,
                                       input logic m, input logic [PW-1:0] pl);
        return {8'h00, r, c, m, pl};
    endfunction

    function automatic bit dst_ok(input logic [3:0] r, input logic [3:0] c);
        int ri = int'(r);
        int ci = int'(c);
        return ((ri == 0 || ri == 5) && ci >= 1 && ci <= 4) ||
               ((ci == 0 || ci == 5) && ri >= 1 && ri <= 4);
    endfunction

    // One clock on u_dut with model update and a full compare of its outputs.
    task automatic step(input bit push, input logic [3:0] r, input logic [3:0] c,
                        input logic m, input logic [PW-1:0] pl, input bit pop);
        bit wr, rd;
        int pre_sz;
        logic [39:0] e;
        d_push = push; d_row = r; d_col = c; d_mode = m; d_pl = pl; d_pop = pop;
        @(posedge clk);
        pre_sz = q.size();
        wr = push && dst_ok(r, c) && pre_sz != 8;
        rd = m_pend && pop;
        if (push && !wr && m_drop < 65535) m_drop++;
        if (rd) begin
            void'(q.pop_front());
            if (m_tx < 65535) m_tx++;
        end
        if (wr) q.push_back(mk(r, c, m, pl));
        if (m_pend) m_pend = rd ? (q.size() > 0) : 1'b1;
        else        m_pend = (pre_sz > 0);
        #1;
        d_push = 1'b0; d_pop = 1'b0;
        e = '0;
        if (m_pend && q.size() > 0) e = q[0];
        chk("pndng", 64'(d_pnd), 64'(m_pend));
        chk("data", 64'(d_data), 64'(e));
        chk("full", 64'(d_full), 64'(q.size() == 8));
        chk("tx_count", 64'(d_tx), 64'(m_tx));
        chk("drop_count", 64'(d_drop), 64'(m_drop));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() > 0 || m_pend); i++)
            step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1);
        chk("drain_done", 64'(q.size()), 64'd0);
    endtask

    localparam bit GAP_PAT[12] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        vec_t vt[12];
        int   drop0;

        vt[0]  = '{4'd0, 4'd2, 1'b1, 23'h05A5A5, 1'b1};
        vt[1]  = '{4'd0, 4'd0, 1'b0, 23'h000001, 1'b0};
        vt[2]  = '{4'd3, 4'd3, 1'b0, 23'h000002, 1'b0};
        vt[3]  = '{4'd5, 4'd4, 1'b0, 23'h000003, 1'b1};
        vt[4]  = '{4'd0, 4'd5, 1'b1, 23'h000004, 1'b0};
        vt[5]  = '{4'd2, 4'd0, 1'b1, 23'h000005, 1'b1};
        vt[6]  = '{4'd4, 4'd5, 1'b0, 23'h7FFFFF, 1'b1};
        vt[7]  = '{4'd5, 4'd5, 1'b0, 23'h000007, 1'b0};
        vt[8]  = '{4'd6, 4'd1, 1'b0, 23'h000008, 1'b0};
        vt[9]  = '{4'd1, 4'd6, 1'b1, 23'h000009, 1'b0};
        vt[10] = '{4'd0, 4'd1, 1'b0, 23'h00000A, 1'b1};
        vt[11] = '{4'd5, 4'd1, 1'b1, 23'h00000B, 1'b1};

        d_push = 0; d_row = 0; d_col = 0; d_mode = 0; d_pl = 0; d_pop = 0;
        g_push = 0; g_row = 0; g_col = 0; g_mode = 0; g_pl = 0; g_pop = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        chk("rst_pndng", 64'(d_pnd), 64'd0);
        chk("rst_data", 64'(d_data), 64'd0);
        chk("rst_full", 64'(d_full), 64'd0);
        chk("rst_tx", 64'(d_tx), 64'd0);
        chk("rst_drop", 64'(d_drop), 64'd0);
        chk("rst_gap_pndng", 64'(g_pnd), 64'd0);

        // Gap instance: two queued packets, popin held high.
        g_row = 4'd0; g_col = 4'd1; g_pl = 23'h111111; g_push = 1'b1;
        @(posedge clk); #1;
        g_col = 4'd2; g_pl = 23'h222222;
        @(posedge clk); #1;
        g_push = 1'b0; g_pop = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("gap_pndng", 64'(g_pnd), 64'(GAP_PAT[i]));
            if (i == 0) chk("gap_head0", 64'(g_data), 64'(mk(4'd0, 4'd1, 1'b0, 23'h111111)));
            if (i == 4) chk("gap_head1", 64'(g_data), 64'(mk(4'd0, 4'd2, 1'b0, 23'h222222)));
            @(posedge clk); #1;
        end
        g_pop = 1'b0;
        chk("gap_tx", 64'(g_tx), 64'd2);

        // First packet, popin low: one-cycle latency then stable head.
        step(1'b1, 4'd0, 4'd2, 1'b1, 23'h05A5A5, 1'b0);
        chk("lat_low", 64'(d_pnd), 64'd0);
        idle(1);
        chk("lat_high", 64'(d_pnd), 64'd1);
        chk("first_pkt", 64'(d_data), 64'({8'h00, 4'h0, 4'h2, 1'b1, 23'h05A5A5}));
        idle(20);
        chk("first_stable", 64'(d_data), 64'({8'h00, 4'h0, 4'h2, 1'b1, 23'h05A5A5}));
        drain();

        foreach (vt[i]) begin
            drop0 = m_drop;
            step(1'b1, vt[i].row, vt[i].col, vt[i].mode, vt[i].pl, 1'b0);
            chk("vec_drop", 64'(d_drop - 16'(drop0)), 64'(!vt[i].exp_ok));
            drain();
        end

        // Fill, overflow, push+pop while full, then ordered drain.
        for (int i = 0; i < 8; i++) step(1'b1, 4'd5, 4'd3, 1'b0, 23'(i + 16), 1'b0);
        chk("full_after8", 64'(d_full), 64'd1);
        drop0 = m_drop;
        step(1'b1, 4'd5, 4'd3, 1'b0, 23'h0000FF, 1'b0);
        chk("ninth_drop", 64'(d_drop - 16'(drop0)), 64'd1);
        step(1'b1, 4'd1, 4'd0, 1'b0, 23'h0000EE, 1'b1);
        chk("pushpop_full_drop", 64'(d_drop - 16'(drop0)), 64'd2);
        chk("pushpop_full_flag", 64'(d_full), 64'd0);
        step(1'b1, 4'd1, 4'd0, 1'b0, 23'h0000DD, 1'b0);
        chk("refill", 64'(d_full), 64'd1);
        for (int i = 0; i < 30; i++) step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'(i % 2));
        chk("fill_empty", 64'(d_pnd), 64'd0);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 6, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)), 23'($urandom), 1'($urandom_range(0, 1)));

        // Asynchronous reset with packets pending.
        drain();
        for (int i = 0; i < 4; i++) step(1'b1, 4'd0, 4'd3, 1'b0, 23'(i + 100), 1'b0);
        idle(1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("arst_pndng", 64'(d_pnd), 64'd0);
        chk("arst_data", 64'(d_data), 64'd0);
        chk("arst_full", 64'(d_full), 64'd0);
        chk("arst_tx", 64'(d_tx), 64'd0);
        chk("arst_drop", 64'(d_drop), 64'd0);
        q.delete(); m_pend = 1'b0; m_tx = 0; m_drop = 0;
        @(negedge clk) reset = 1'b1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
